// File: rtl/l1i_pkg.sv
// Shared types and address helpers for the L1 instruction cache.
// The helpers return 64-bit values; callers size-cast to their index/tag widths.
package l1i_pkg;

  typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;

  localparam int LINE_BYTES = 64;
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam logic [3:0] SNOOP_MAKE_INVALID = 4'hD;

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
    return (addr >> OFFSET_W) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
    return addr >> (OFFSET_W + idx_w);
  endfunction

endpackage

// File: rtl/l1i_tag_array.sv
// Valid + tag storage for the direct-mapped L1 I-cache.
// Provides a fetch read port, a snoop compare port, a fill write port and a snoop clear port.
module l1i_tag_array #(
  parameter int SETS  = 256,
  parameter int IDX_W = 8,
  parameter int TAG_W = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic [IDX_W-1:0] snp_idx,
  input  logic [TAG_W-1:0] snp_tag,
  output logic             snp_hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign snp_hit  = valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);

  // A fill overrides a clear on the same set: the snoop only matched the old
  // line, and a snoop on the incoming line arrives here as wr_valid = 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx] <= 1'b0;
      if (wr_en)  valid_q[wr_idx]  <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/l1_icache.sv
// Read-only direct-mapped L1 instruction cache returning whole 64-byte lines,
// filled from the LLC on a miss and invalidated by AXI MakeInvalid snoops.
module l1_icache
  import l1i_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BITS  = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
  input  logic                  S_R_ADDR_VALID,
  output logic [LINE_BITS-1:0]  S_R_DATA,
  output logic                  S_R_DATA_VALID,
  output logic [ADDR_WIDTH-1:0] L2_S_R_ADDR,
  output logic                  L2_S_R_ADDR_VALID,
  input  logic [LINE_BITS-1:0]  L2_S_R_DATA,
  input  logic                  L2_S_R_DATA_VALID,
  input  logic [3:0]            m_axi_acsnoop,
  input  logic [ADDR_WIDTH-1:0] m_axi_acaddr
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFFSET_W - IDX_W;
  localparam int LA_W  = ADDR_WIDTH - OFFSET_W;

  state_t state, next_state;

  logic [IDX_W-1:0]     req_idx, snp_idx, fill_idx;
  logic [TAG_W-1:0]     req_tag, snp_tag, fill_tag, rd_tag;
  logic [LA_W-1:0]      miss_line;
  logic                 rd_valid, snp_hit, is_mkinv, snoop_kill, fill_kill, hit;
  logic                 load_hit, load_miss, fill_en;
  logic [LINE_BITS-1:0] data_mem [SETS];

  assign req_idx  = IDX_W'(addr_index(S_R_ADDR, IDX_W));
  assign req_tag  = TAG_W'(addr_tag(S_R_ADDR, IDX_W));
  assign snp_idx  = IDX_W'(addr_index(m_axi_acaddr, IDX_W));
  assign snp_tag  = TAG_W'(addr_tag(m_axi_acaddr, IDX_W));
  assign fill_idx = miss_line[IDX_W-1:0];
  assign fill_tag = miss_line[LA_W-1:IDX_W];

  assign is_mkinv   = (m_axi_acsnoop == SNOOP_MAKE_INVALID);
  assign snoop_kill = is_mkinv && (m_axi_acaddr[ADDR_WIDTH-1:OFFSET_W] == S_R_ADDR[ADDR_WIDTH-1:OFFSET_W]);
  assign fill_kill  = is_mkinv && (m_axi_acaddr[ADDR_WIDTH-1:OFFSET_W] == miss_line);
  assign hit        = rd_valid && (rd_tag == req_tag) && !snoop_kill;

  l1i_tag_array #(
    .SETS (SETS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_tags (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .snp_idx (snp_idx),
    .snp_tag (snp_tag),
    .snp_hit (snp_hit),
    .wr_en   (fill_en),
    .wr_idx  (fill_idx),
    .wr_tag  (fill_tag),
    .wr_valid(!fill_kill),
    .clr_en  (is_mkinv && snp_hit),
    .clr_idx (snp_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_hit   = 1'b0;
    load_miss  = 1'b0;
    fill_en    = 1'b0;
    case (state)
      IDLE: begin
        if (S_R_ADDR_VALID) begin
          if (hit) begin
            load_hit   = 1'b1;
            next_state = DONE;
          end else begin
            load_miss  = 1'b1;
            next_state = MISS;
          end
        end
      end
      MISS: begin
        if (L2_S_R_DATA_VALID) begin
          fill_en    = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign S_R_DATA_VALID    = (state == DONE);
  assign L2_S_R_ADDR_VALID = (state == MISS);
  assign L2_S_R_ADDR       = {miss_line, {OFFSET_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_line <= '0;
      S_R_DATA  <= '0;
    end else begin
      if (load_miss) miss_line <= S_R_ADDR[ADDR_WIDTH-1:OFFSET_W];
      if (load_hit)     S_R_DATA <= data_mem[req_idx];
      else if (fill_en) S_R_DATA <= L2_S_R_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) data_mem[fill_idx] <= L2_S_R_DATA;
  end

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: cold miss, hit, conflict, snoops, snoop on fill, reset mid-miss.
module tb_l1_icache;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  S_R_ADDR;
  logic         S_R_ADDR_VALID;
  logic [511:0] S_R_DATA;
  logic         S_R_DATA_VALID;
  logic [63:0]  L2_S_R_ADDR;
  logic         L2_S_R_ADDR_VALID;
  logic [511:0] L2_S_R_DATA;
  logic         L2_S_R_DATA_VALID;
  logic [3:0]   m_axi_acsnoop;
  logic [63:0]  m_axi_acaddr;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [511:0] PAT_P = {16{32'hA5A5_0001}};
  localparam logic [511:0] PAT_Q = {16{32'h5A5A_0002}};
  localparam logic [511:0] PAT_R = {16{32'h3C3C_0003}};
  localparam logic [511:0] PAT_S = {16{32'hC3C3_0004}};
  localparam logic [511:0] PAT_T = {16{32'h0F0F_0005}};

  l1_icache dut (
    .clk              (clk),
    .reset            (reset),
    .S_R_ADDR         (S_R_ADDR),
    .S_R_ADDR_VALID   (S_R_ADDR_VALID),
    .S_R_DATA         (S_R_DATA),
    .S_R_DATA_VALID   (S_R_DATA_VALID),
    .L2_S_R_ADDR      (L2_S_R_ADDR),
    .L2_S_R_ADDR_VALID(L2_S_R_ADDR_VALID),
    .L2_S_R_DATA      (L2_S_R_DATA),
    .L2_S_R_DATA_VALID(L2_S_R_DATA_VALID),
    .m_axi_acsnoop    (m_axi_acsnoop),
    .m_axi_acaddr     (m_axi_acaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One fetch. On a miss the LLC answers after lat cycles of held request;
  // optionally a snoop (code snp_code, address snp_addr) coincides with the fill.
  task automatic fetch(input string name, input logic [63:0] addr, input bit exp_miss,
                       input logic [511:0] fill, input logic [511:0] exp_data, input int lat,
                       input logic [3:0] snp_code, input logic [63:0] snp_addr);
    S_R_ADDR       = addr;
    S_R_ADDR_VALID = 1'b1;
    @(negedge clk);
    check({name, ".l2_req"}, 512'(L2_S_R_ADDR_VALID), 512'(exp_miss));
    if (exp_miss) begin
      check({name, ".l2_addr"}, 512'(L2_S_R_ADDR), 512'(addr & ~64'h3F));
      check({name, ".no_early_pulse"}, 512'(S_R_DATA_VALID), 512'(0));
      repeat (lat - 1) @(negedge clk);
      check({name, ".l2_held"}, 512'(L2_S_R_ADDR_VALID), 512'(1));
      L2_S_R_DATA       = fill;
      L2_S_R_DATA_VALID = 1'b1;
      m_axi_acsnoop     = snp_code;
      m_axi_acaddr      = snp_addr;
      @(negedge clk);
      L2_S_R_DATA_VALID = 1'b0;
      m_axi_acsnoop     = 4'h0;
      check({name, ".l2_drop"}, 512'(L2_S_R_ADDR_VALID), 512'(0));
    end
    check({name, ".pulse"}, 512'(S_R_DATA_VALID), 512'(1));
    check({name, ".data"}, S_R_DATA, exp_data);
    S_R_ADDR_VALID = 1'b0;
    @(negedge clk);
    check({name, ".pulse_once"}, 512'(S_R_DATA_VALID), 512'(0));
  endtask

  task automatic snoop(input logic [3:0] code, input logic [63:0] addr);
    m_axi_acsnoop = code;
    m_axi_acaddr  = addr;
    @(negedge clk);
    m_axi_acsnoop = 4'h0;
  endtask

  initial begin
    reset             = 1'b1;
    S_R_ADDR          = '0;
    S_R_ADDR_VALID    = 1'b0;
    L2_S_R_DATA       = '0;
    L2_S_R_DATA_VALID = 1'b0;
    m_axi_acsnoop     = 4'h0;
    m_axi_acaddr      = '0;
    repeat (2) @(negedge clk);
    check("rst.data_valid", 512'(S_R_DATA_VALID), 512'(0));
    check("rst.l2_valid", 512'(L2_S_R_ADDR_VALID), 512'(0));
    check("rst.data", S_R_DATA, 512'(0));
    check("rst.l2_addr", 512'(L2_S_R_ADDR), 512'(0));
    reset = 1'b0;
    @(negedge clk);

    fetch("cold", 64'h1004, 1'b1, PAT_P, PAT_P, 5, 4'h0, 64'h0);
    fetch("warm", 64'h1038, 1'b0, '0, PAT_P, 0, 4'h0, 64'h0);
    // 0x5000 shares index 0x40 with 0x1000 but has a different tag
    fetch("evict", 64'h5000, 1'b1, PAT_Q, PAT_Q, 3, 4'h0, 64'h0);
    fetch("conflict", 64'h1000, 1'b1, PAT_P, PAT_P, 2, 4'h0, 64'h0);

    snoop(4'h0, 64'h1010);
    fetch("snp_ctrl", 64'h1000, 1'b0, '0, PAT_P, 0, 4'h0, 64'h0);
    snoop(4'hD, 64'h1010);
    fetch("snp_inv", 64'h1000, 1'b1, PAT_R, PAT_R, 1, 4'h0, 64'h0);

    fetch("snp_fill", 64'h2000, 1'b1, PAT_S, PAT_S, 2, 4'hD, 64'h2020);
    fetch("snp_fill_re", 64'h2000, 1'b1, PAT_T, PAT_T, 1, 4'h0, 64'h0);

    // snoop on another (cached) set while 0x3000 fills: both must take effect
    fetch("snp_other", 64'h3000, 1'b1, PAT_Q, PAT_Q, 2, 4'hD, 64'h1000);
    fetch("snp_other_hit", 64'h3010, 1'b0, '0, PAT_Q, 0, 4'h0, 64'h0);
    fetch("snp_other_inv", 64'h1000, 1'b1, PAT_P, PAT_P, 1, 4'h0, 64'h0);

    S_R_ADDR       = 64'h6000;
    S_R_ADDR_VALID = 1'b1;
    @(negedge clk);
    check("rmiss.l2_req", 512'(L2_S_R_ADDR_VALID), 512'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rmiss.l2_drop", 512'(L2_S_R_ADDR_VALID), 512'(0));
    check("rmiss.no_pulse", 512'(S_R_DATA_VALID), 512'(0));
    reset          = 1'b0;
    S_R_ADDR_VALID = 1'b0;
    L2_S_R_DATA       = PAT_R;
    L2_S_R_DATA_VALID = 1'b1;
    @(negedge clk);
    L2_S_R_DATA_VALID = 1'b0;
    @(negedge clk);
    check("late_fill.no_pulse", 512'(S_R_DATA_VALID), 512'(0));
    check("late_fill.idle", 512'(L2_S_R_ADDR_VALID), 512'(0));
    fetch("post_rst_3000", 64'h3000, 1'b1, PAT_S, PAT_S, 1, 4'h0, 64'h0);
    fetch("post_rst_1038", 64'h1038, 1'b1, PAT_T, PAT_T, 1, 4'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
